// File: rtl/dram_burst.sv
// Behavioural DRAM model: valid/ready request port, single-beat writes, and burst reads
// returned through a fixed-latency pipeline with a last-beat flag.
//
// state | meaning
// IDLE  | ready for a request; writes complete here at one per cycle
// ISSUE | reading one word per cycle into the latency pipeline
// DRAIN | all beats issued; waiting for the last beat to leave the pipeline
module dram_burst #(
   parameter int                 D_WIDTH   = 8,
   parameter int                 A_WIDTH   = 21,
   parameter int                 BURST_MAX = 16,
   parameter int                 LEN_W     = 4,
   parameter int                 RD_LAT    = 2,
   parameter logic [D_WIDTH-1:0] FILL      = 8'hFF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_we,
   input  logic [A_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [D_WIDTH-1:0] wr_data,
   output logic               rd_valid,
   output logic [D_WIDTH-1:0] rd_data,
   output logic               rd_last,
   output logic               busy
);

   localparam int A_DEPTH = 1 << A_WIDTH;
   localparam int BW      = LEN_W + 1;

   if (BURST_MAX < 2 || (BURST_MAX & (BURST_MAX - 1)) != 0) begin : g_bad_burst
      $error("dram_burst: BURST_MAX must be a power of two >= 2");
   end
   if (RD_LAT < 1) begin : g_bad_lat
      $error("dram_burst: RD_LAT must be >= 1");
   end
   if (LEN_W != $clog2(BURST_MAX)) begin : g_bad_len
      $error("dram_burst: LEN_W must equal clog2(BURST_MAX)");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                        state_q, state_d;
   logic [A_WIDTH-1:0]            addr_q, addr_d;
   logic [BW-1:0]                 beats_q, beats_d;
   logic [RD_LAT-1:0]             vld_q, lst_q;
   logic [RD_LAT-1:0][D_WIDTH-1:0] dat_q;

   // Words are stored XOR FILL so that the zero-initialised array reads back as FILL.
   logic [D_WIDTH-1:0]            mem_q [A_DEPTH];

   logic accept, wr_en, rd_en, issue, issue_last;

   assign accept     = req_valid && (state_q == IDLE);
   assign wr_en      = accept && req_we;
   assign rd_en      = accept && !req_we;
   assign issue      = (state_q == ISSUE);
   assign issue_last = issue && (beats_q == BW'(1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beats_d = beats_q;
      case (state_q)
         IDLE: begin
            if (rd_en) begin
               addr_d  = req_addr;
               beats_d = BW'(req_len) + BW'(1);
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            addr_d  = addr_q + A_WIDTH'(1);
            beats_d = beats_q - BW'(1);
            if (beats_q == BW'(1)) state_d = DRAIN;
         end
         DRAIN: begin
            if (vld_q[RD_LAT-1] && lst_q[RD_LAT-1]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beats_q <= '0;
         vld_q   <= '0;
         lst_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         beats_q  <= beats_d;
         vld_q[0] <= issue;
         lst_q[0] <= issue_last;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
      end
   end

   // Data stages carry no reset; rd_data is masked by the valid bit instead.
   always_ff @(posedge clk) begin
      dat_q[0] <= mem_q[addr_q] ^ FILL;
      for (int i = 1; i < RD_LAT; i++) begin
         dat_q[i] <= dat_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem_q[req_addr] <= wr_data ^ FILL;
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = ~req_ready;
   assign rd_valid  = vld_q[RD_LAT-1];
   assign rd_last   = vld_q[RD_LAT-1] && lst_q[RD_LAT-1];
   assign rd_data   = vld_q[RD_LAT-1] ? dat_q[RD_LAT-1] : '0;

endmodule
